key_event_decoder: RTL and testbench

Turns one raw push-button into classified single-cycle events: short press, double press, long press and auto-repeat while held. Debouncing is built in, and a 2-flop synchronizer sits in front of it. Each `HDMI_TOP` button feeds one instance, and the outputs drive the parameter/mode control logic directly. It is the consumer side of a key line: a plain debounce only yields press flags, while this block decides what each press means.

---
 rtl/key_event_decoder.sv | 155 +++++++++++++++
 tb/tb_key_event_decoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// key_event_decoder: classifies one active-low push-button into short, double, long and auto-repeat events.
// Ports:
//   sys_clk      - system clock (single domain)
//   sys_rst_n    - asynchronous active-low reset
//   key_in       - raw asynchronous button, 0 = pressed
//   key_down     - debounced level, 1 = pressed
//   short_pulse  - one cycle: a lone short press has completed
//   double_pulse - one cycle: second press of a double press released
//   long_pulse   - one cycle: hold time reached LONG_MAX
//   repeat_pulse - one cycle: every REP_MAX cycles while a long press is held
module key_event_decoder #(
    parameter logic [19:0] DEB_MAX  = 20'd999_999,
    parameter logic [25:0] LONG_MAX = 26'd49_999_999,
    parameter logic [24:0] GAP_MAX  = 25'd14_999_999,
    parameter logic [23:0] REP_MAX  = 24'd9_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_down,
    output logic short_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);
    typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, HOLD} state_t;

    localparam logic [25:0] LONG_END = LONG_MAX - 26'd1;
    localparam logic [25:0] GAP_END  = 26'(GAP_MAX) - 26'd1;
    localparam logic [25:0] REP_END  = 26'(REP_MAX) - 26'd1;

    logic        sync1_q, sync2_q;
    logic [19:0] cnt_deb_q;
    logic        key_down_q, key_prev_q;
    logic        press_ev, rel_ev;
    state_t      state_q;
    logic [25:0] cnt_t_q;
    logic        short_q, double_q, long_q, repeat_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    // key_sync is active-low while key_down is active-high, so equality
    // means the raw level disagrees with the debounced one.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_deb_q  <= '0;
            key_down_q <= 1'b0;
            key_prev_q <= 1'b0;
        end else begin
            key_prev_q <= key_down_q;
            if (sync2_q != key_down_q) begin
                cnt_deb_q <= '0;
            end else if (cnt_deb_q == DEB_MAX) begin
                cnt_deb_q  <= '0;
                key_down_q <= ~key_down_q;
            end else begin
                cnt_deb_q <= cnt_deb_q + 20'd1;
            end
        end
    end

    assign press_ev = key_down_q & ~key_prev_q;
    assign rel_ev   = ~key_down_q & key_prev_q;

    // Release is tested before every timeout, so a release coinciding with
    // a limit always wins. IDLE follows the key_down level so a press that
    // lands while the FSM is returning to IDLE is still picked up.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            cnt_t_q  <= '0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_t_q <= '0;
                    if (key_down_q) state_q <= PRESS1;
                end
                PRESS1: begin
                    if (rel_ev) begin
                        state_q <= WAIT2;
                        cnt_t_q <= '0;
                    end else if (cnt_t_q == LONG_END) begin
                        state_q <= HOLD;
                        cnt_t_q <= '0;
                        long_q  <= 1'b1;
                    end else begin
                        cnt_t_q <= cnt_t_q + 26'd1;
                    end
                end
                WAIT2: begin
                    if (press_ev) begin
                        state_q <= PRESS2;
                        cnt_t_q <= '0;
                    end else if (cnt_t_q == GAP_END) begin
                        state_q <= IDLE;
                        cnt_t_q <= '0;
                        short_q <= 1'b1;
                    end else begin
                        cnt_t_q <= cnt_t_q + 26'd1;
                    end
                end
                PRESS2: begin
                    if (rel_ev) begin
                        state_q  <= IDLE;
                        cnt_t_q  <= '0;
                        double_q <= 1'b1;
                    end else if (cnt_t_q == LONG_END) begin
                        state_q <= HOLD;
                        cnt_t_q <= '0;
                        long_q  <= 1'b1;
                    end else begin
                        cnt_t_q <= cnt_t_q + 26'd1;
                    end
                end
                HOLD: begin
                    if (rel_ev) begin
                        state_q <= IDLE;
                        cnt_t_q <= '0;
                    end else if (cnt_t_q == REP_END) begin
                        cnt_t_q  <= '0;
                        repeat_q <= 1'b1;
                    end else begin
                        cnt_t_q <= cnt_t_q + 26'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_t_q <= '0;
                end
            endcase
        end
    end

    assign key_down     = key_down_q;
    assign short_pulse  = short_q;
    assign double_pulse = double_q;
    assign long_pulse   = long_q;
    assign repeat_pulse = repeat_q;
endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: scoreboard bench predicting key events from press/release timing arithmetic.
module tb_key_event_decoder;
    localparam int DEB = 3, LONG = 40, GAP = 20, REP = 10;

    logic sys_clk = 1'b0, sys_rst_n = 1'b0, key_in = 1'b1;
    logic key_down, short_pulse, double_pulse, long_pulse, repeat_pulse;
    logic kd_prev = 1'b0;
    int   cyc = 0, vectors = 0, miscompares = 0;
    int   exp_q[$];
    int   g_lo[$], g_hi[$];

    key_event_decoder #(
        .DEB_MAX(20'd3), .LONG_MAX(26'd40), .GAP_MAX(25'd20), .REP_MAX(24'd10)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
        .key_down(key_down), .short_pulse(short_pulse), .double_pulse(double_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic string ev_name(input int t);
        case (t)
            0: return "key_rise";
            1: return "key_fall";
            2: return "short";
            3: return "double";
            4: return "long";
            default: return "repeat";
        endcase
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic got, input logic want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b", nm, got, want);
        end
    endtask

    task automatic see(input int t);
        int e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected: got %s at edge %0d, expected nothing", ev_name(t), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e != cyc * 8 + t) begin
                miscompares++;
                $display("FAIL event: got %s at edge %0d, expected %s at edge %0d",
                         ev_name(t), cyc, ev_name(e % 8), e / 8);
            end
        end
    endtask

    // Monitor: every key_down edge and every pulse must match the head of the queue.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            kd_prev = 1'b0;
        end else begin
            while (exp_q.size() > 0 && exp_q[0] / 8 < cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL missed: got nothing, expected %s at edge %0d",
                         ev_name(exp_q[0] % 8), exp_q[0] / 8);
                void'(exp_q.pop_front());
            end
            if (key_down != kd_prev) see(key_down ? 0 : 1);
            kd_prev = key_down;
            if (short_pulse) see(2);
            if (double_pulse) see(3);
            if (long_pulse) see(4);
            if (repeat_pulse) see(5);
            if (int'(short_pulse) + int'(double_pulse) + int'(long_pulse) + int'(repeat_pulse) > 0) begin
                vectors++;
                if (int'(short_pulse) + int'(double_pulse) + int'(long_pulse) + int'(repeat_pulse) > 1) begin
                    miscompares++;
                    $display("FAIL exclusive: got %0b%0b%0b%0b at edge %0d, expected one-hot",
                             short_pulse, double_pulse, long_pulse, repeat_pulse, cyc);
                end
            end
        end
    end

    task automatic push(input int e, input int t);
        exp_q.push_back(e * 8 + t);
    endtask

    // Held press from rise r to fall f: long after LONG+1 edges, then a repeat
    // every REP edges strictly before the release takes effect.
    task automatic long_rep(input int r, input int f);
        push(r + LONG + 1, 4);
        for (int t = r + LONG + 1 + REP; t <= f; t += REP) push(t, 5);
    endtask

    // Presses g_lo[j] low cycles each, followed by g_hi[j] high cycles.
    // key_down edges lag key_in by DEB+3 edges in both directions.
    task automatic gesture();
        int r[$], f[$];
        int t, i;
        t = cyc;
        for (int j = 0; j < g_lo.size(); j++) begin
            r.push_back(t + DEB + 3);
            f.push_back(t + g_lo[j] + DEB + 3);
            push(r[j], 0);
            push(f[j], 1);
            t += g_lo[j] + g_hi[j];
        end
        i = 0;
        while (i < r.size()) begin
            if (f[i] - r[i] > LONG) begin
                long_rep(r[i], f[i]);
                i++;
            end else if (i + 1 < r.size() && r[i + 1] - f[i] <= GAP) begin
                if (f[i + 1] - r[i + 1] > LONG) long_rep(r[i + 1], f[i + 1]);
                else push(f[i + 1] + 1, 3);
                i += 2;
            end else begin
                push(f[i] + GAP + 1, 2);
                i++;
            end
        end
        exp_q.sort();
        for (int j = 0; j < g_lo.size(); j++) begin
            key_in = 1'b0;
            repeat (g_lo[j]) tick();
            key_in = 1'b1;
            repeat (g_hi[j]) tick();
        end
        g_lo.delete();
        g_hi.delete();
    endtask

    task automatic glitch(input int n);
        key_in = 1'b0;
        repeat (n) tick();
        key_in = 1'b1;
        repeat (20) tick();
        chk("glitch_key_down", key_down, 1'b0);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_key_down"}, key_down, 1'b0);
        chk({nm, "_short"}, short_pulse, 1'b0);
        chk({nm, "_double"}, double_pulse, 1'b0);
        chk({nm, "_long"}, long_pulse, 1'b0);
        chk({nm, "_repeat"}, repeat_pulse, 1'b0);
    endtask

    initial begin
        int k, n;
        repeat (3) tick();
        chk_idle("in_reset");
        sys_rst_n = 1'b1;
        repeat (2) tick();
        chk_idle("after_reset");
        glitch(3);
        g_lo = '{15};         g_hi = '{40};         gesture();
        g_lo = '{15, 15};     g_hi = '{10, 40};     gesture();
        g_lo = '{15, 15};     g_hi = '{20, 40};     gesture();
        g_lo = '{15, 15};     g_hi = '{21, 40};     gesture();
        g_lo = '{75};         g_hi = '{40};         gesture();
        g_lo = '{15, 60};     g_hi = '{10, 40};     gesture();
        for (int g = 0; g < 25; g++) begin
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) begin
                g_lo.push_back(($urandom_range(0, 2) == 0) ? $urandom_range(45, 90) : $urandom_range(5, 30));
                g_hi.push_back((j == n - 1) ? 40 : $urandom_range(5, 30));
            end
            gesture();
            if ($urandom_range(0, 3) == 0) glitch($urandom_range(1, 3));
        end
        k = cyc;
        push(k + DEB + 3, 0);
        long_rep(k + DEB + 3, k + 59);
        exp_q.sort();
        key_in = 1'b0;
        repeat (60) tick();
        sys_rst_n = 1'b0;
        #1;
        chk_idle("async_reset");
        repeat (2) tick();
        sys_rst_n = 1'b1;
        g_lo = '{50}; g_hi = '{40}; gesture();
        repeat (30) tick();
        while (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL missed: got nothing, expected %s at edge %0d", ev_name(exp_q[0] % 8), exp_q[0] / 8);
            void'(exp_q.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
